apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Two-requester APB master that shares one APB bus between requester 0 and requester 1 using round-robin arbitration.
- Sequences each granted command through the APB SETUP/ACCESS phases and decodes the address bit to drive PSELECT1 (slave 1) or PSELECT2 (slave 2).
- Returns read data and error status to the requester that owned the transfer.
- Sits between command sources (test sequencers, CPU-side logic) and the existing APB slaves.

Parameters:
- ADDR_W, 7, APB address width.
- DATA_W, 8, APB read/write data width.
- SEL_BIT, 6, address bit selecting the slave: 1 -> PSELECT1, 0 -> PSELECT2.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY=0 before forced termination; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- req0_valid  in  1  requester 0 command pending.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  target address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  command accepted this cycle (combinational).
- rsp0_valid  out  1  one-cycle response pulse.
- rsp0_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp0_err  out  1  PSLVERR or timeout.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: same as requester 0, for requester 1.
- PSELECT1  out  1  slave 1 select.
- PSELECT2  out  1  slave 2 select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  muxed slave read data.
- PREADY  in  1  muxed slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS. All APB outputs and response outputs are registered except reqN_ready.
- IDLE:
  - If any reqN_valid is high, pick a grant g.
  - If both are valid, g = the requester not equal to last_grant; otherwise g = the single valid requester.
  - reqN_ready = 1 for g only, combinationally, in that cycle.
  - On the clock edge: latch write, addr and wdata; set last_grant = g; go to SETUP.
- SETUP (exactly 1 cycle):
  - PSELECTx = 1 per PADDR[SEL_BIT]; PENABLE = 0; PADDR, PWRITE and PWDATA come from the latch.
  - Next state: ACCESS.
- ACCESS:
  - PENABLE = 1; PSELECTx held; timeout counter increments each cycle PREADY = 0.
  - If PREADY = 1: next cycle rsp_g_valid = 1 for one cycle; rsp_g_rdata = PRDATA for reads, 0 for writes; rsp_g_err = PSLVERR. Go to IDLE.
  - If the counter reaches TIMEOUT with PREADY still 0 (TIMEOUT > 0): next cycle rsp_g_valid = 1, rsp_g_err = 1, rsp_g_rdata = 0. Go to IDLE.
- Leaving ACCESS: PSELECT1, PSELECT2 and PENABLE drop to 0. PADDR, PWRITE and PWDATA hold their last values. The counter clears.
- Latency: accept edge -> SETUP 1 cycle -> ACCESS ≥1 cycle -> response 1 cycle after the PREADY edge. Minimum of 3 cycles between successive accepts.
- Requester rule:
  - reqN_valid and payload must stay stable until reqN_ready.
  - A request that drops valid before ready is treated as withdrawn, with no response.
  - Requests arriving while busy wait in place; there is no queue.
- Exactly one PSELECTx is high in SETUP and ACCESS; both are low in IDLE.
- Reset (PRESET = 1 at an edge, including mid-transfer):
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0: PSELECT1/2, PENABLE, PWRITE, PADDR, PWDATA, rsp*_valid, rsp*_rdata, rsp*_err.
  - Counter = 0. An aborted transfer produces no response.
  - reqN_ready is forced to 0 while PRESET = 1.
- PSLVERR is sampled only in the ACCESS cycle where PREADY = 1.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS};
  - ADDR_W/DATA_W defaults;
  - SEL_BIT constant;
  - a command struct {write, addr, wdata}.
- One natural sub-module: apb_rr_arb2, a 2-way round-robin arbiter holding last_grant, with a grant-enable input.
- FSM, latch and timeout counter stay in the top module.

Test Plan:
- Single write: req0 write addr 0x41, data 0x05, slave PREADY=1 immediately -> PSELECT1=1 with PENABLE=0 for 1 cycle, then PENABLE=1 for 1 cycle, PWDATA=0x05; rsp0_valid pulse with err=0, rdata=0.
- Read from slave 2 with wait states: req1 read addr 0x03, PREADY held low 3 ACCESS cycles, then high with PRDATA=0x09 -> PSELECT2 high for 5 cycles; rsp1_rdata=0x09, err=0.
- Contention: both valid from reset, 4 writes each -> grants alternate 0,1,0,1,...; no requester is served twice in a row while the other is waiting.
- Error and timeout:
  - PSLVERR=1 with PREADY=1 on addr 0x45 -> rsp0_err=1.
  - With TIMEOUT=16 and PREADY stuck at 0 -> exactly 16 ACCESS cycles, then rsp err=1, rdata=0, bus back to IDLE.
- Reset mid-ACCESS: assert PRESET during a PREADY=0 wait -> next edge all outputs 0, no rsp pulse; a subsequent req0 completes normally.
- Back-to-back on one requester: req0 valid continuously with reads of 0x40..0x45 (slave 1 preloaded 0..5) -> accepts every 3 cycles; rdata 0,1,2,3,4,5 in order.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the round-robin APB master
package apb_pkg;

   localparam int APB_ADDR_W  = 7;
   localparam int APB_DATA_W  = 8;
   localparam int APB_SEL_BIT = 6;
   localparam int APB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/apb_rr_master_if.sv
// rtl/apb_rr_master_if.sv - APB bus between the shared master and its two slaves
interface apb_rr_master_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) ();
   logic              PSELECT1;
   logic              PSELECT2;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_rr_arb2.sv
// rtl/apb_rr_arb2.sv - two-way round-robin arbiter; a tie goes to the requester not served last
module apb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] ready,
   output logic       grant_valid,
   output logic       grant
);
   logic last_grant;

   always_comb begin
      grant       = (valid == 2'b11) ? ~last_grant : valid[1];
      grant_valid = en & (|valid);
      ready       = 2'b00;
      if (grant_valid)
         ready = grant ? 2'b10 : 2'b01;
   end

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b1;
      else if (grant_valid)
         last_grant <= grant;
   end
endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - two-requester APB master: arbitration, SETUP/ACCESS sequencing, timeout
module apb_rr_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int SEL_BIT = APB_SEL_BIT,
   parameter int TIMEOUT = APB_TIMEOUT
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   apb_rr_master_if.master   bus
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            state;
   logic              owner;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        ready;
   logic              gnt_valid;
   logic              gnt;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              timed_out;
   logic              done;
   logic [DATA_W-1:0] done_rdata;
   logic              done_err;

   apb_rr_arb2 u_arb (
      .clk         (PCLK),
      .rst         (PRESET),
      .en          ((state == IDLE) && !PRESET),
      .valid       ({req1_valid, req0_valid}),
      .ready       (ready),
      .grant_valid (gnt_valid),
      .grant       (gnt)
   );

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   assign sel_write = gnt ? req1_write : req0_write;
   assign sel_addr  = gnt ? req1_addr  : req0_addr;
   assign sel_wdata = gnt ? req1_wdata : req0_wdata;

   // PREADY wins over a timeout landing in the same cycle.
   assign timed_out  = (TIMEOUT > 0) && (cnt == CNT_LAST) && !bus.PREADY;
   assign done       = bus.PREADY || timed_out;
   assign done_rdata = (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : '0;
   assign done_err   = bus.PREADY ? bus.PSLVERR : 1'b1;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state        <= IDLE;
         owner        <= 1'b0;
         cnt          <= '0;
         bus.PSELECT1 <= 1'b0;
         bus.PSELECT2 <= 1'b0;
         bus.PENABLE  <= 1'b0;
         bus.PWRITE   <= 1'b0;
         bus.PADDR    <= '0;
         bus.PWDATA   <= '0;
         rsp0_valid   <= 1'b0;
         rsp0_rdata   <= '0;
         rsp0_err     <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp1_rdata   <= '0;
         rsp1_err     <= 1'b0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  bus.PWRITE   <= sel_write;
                  bus.PADDR    <= sel_addr;
                  bus.PWDATA   <= sel_wdata;
                  bus.PSELECT1 <= sel_addr[SEL_BIT];
                  bus.PSELECT2 <= ~sel_addr[SEL_BIT];
                  owner        <= gnt;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               bus.PENABLE <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (done) begin
                  bus.PSELECT1 <= 1'b0;
                  bus.PSELECT2 <= 1'b0;
                  bus.PENABLE  <= 1'b0;
                  cnt          <= '0;
                  state        <= IDLE;
                  if (owner) begin
                     rsp1_valid <= 1'b1;
                     rsp1_rdata <= done_rdata;
                     rsp1_err   <= done_err;
                  end else begin
                     rsp0_valid <= 1'b1;
                     rsp0_rdata <= done_rdata;
                     rsp0_err   <= done_err;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master
module tb_apb_rr_master;
   import apb_pkg::*;

   localparam int STUCK = 99;

   typedef struct {
      int         req;
      cmd_t       cmd;
      int         waits;
      logic       serr;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
   logic [6:0] req0_addr;
   logic [7:0] req0_wdata, rsp0_rdata;
   logic       req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
   logic [6:0] req1_addr;
   logic [7:0] req1_wdata, rsp1_rdata;

   int         checks = 0;
   int         errors = 0;
   int         s_waits = 0;
   logic       s_err = 1'b0;
   int         slv_cnt = 0;
   logic       preload_req = 1'b0;
   logic [7:0] mem [128];
   logic [7:0] ref_mem [128];
   vec_t       vecs [$];

   apb_rr_master_if #(.ADDR_W(7), .DATA_W(8)) bus ();

   apb_rr_master dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .bus(bus)
   );

   always #5 PCLK = ~PCLK;

   function automatic logic [7:0] init_val(int i);
      return (i == 3) ? 8'h09 : 8'(i & 63);
   endfunction

   // Slave: stalls s_waits ACCESS cycles (forever when STUCK), then completes.
   assign bus.PREADY  = bus.PENABLE && (bus.PSELECT1 || bus.PSELECT2) &&
                        (s_waits < STUCK) && (slv_cnt >= s_waits);
   assign bus.PRDATA  = mem[bus.PADDR];
   assign bus.PSLVERR = s_err;

   always @(posedge PCLK) begin
      slv_cnt <= (bus.PENABLE && !bus.PREADY) ? slv_cnt + 1 : 0;
      if (preload_req) begin
         for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
      end else if (bus.PENABLE && bus.PREADY && bus.PWRITE && !s_err) begin
         mem[bus.PADDR] <= bus.PWDATA;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic preload();
      preload_req = 1'b1;
      @(posedge PCLK);
      #1 preload_req = 1'b0;
      for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
   endtask

   task automatic add_vec(input int r, input logic w, input logic [6:0] a, input logic [7:0] d,
                          input int waits, input logic serr, input logic [7:0] rd, input logic err);
      vec_t v;
      v.req = r; v.cmd.write = w; v.cmd.addr = a; v.cmd.wdata = d;
      v.waits = waits; v.serr = serr; v.exp_rdata = rd; v.exp_err = err;
      vecs.push_back(v);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_sel1"}, bus.PSELECT1, 0);
      chk({tag, "_sel2"}, bus.PSELECT2, 0);
      chk({tag, "_penable"}, bus.PENABLE, 0);
      chk({tag, "_pwrite"}, bus.PWRITE, 0);
      chk({tag, "_paddr"}, bus.PADDR, 0);
      chk({tag, "_pwdata"}, bus.PWDATA, 0);
      chk({tag, "_rsp"}, {rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata}, 0);
   endtask

   // One isolated transfer from an idle bus, checked phase by phase.
   task automatic run_txn(input int r, input logic w, input logic [6:0] a, input logic [7:0] d,
                          input int waits, input logic serr,
                          input logic [7:0] exp_rd, input logic exp_err);
      int   acc;
      logic got;
      int   exp_acc;
      exp_acc = (waits >= STUCK) ? 16 : waits + 1;
      @(negedge PCLK);
      s_waits = waits;
      s_err   = serr;
      if (r == 0) begin
         req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
      end
      #1;
      chk("ready_own", (r == 0) ? req0_ready : req1_ready, 1);
      chk("ready_other", (r == 0) ? req1_ready : req0_ready, 0);
      @(posedge PCLK);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge PCLK);
      chk("setup_sel1", bus.PSELECT1, a[6]);
      chk("setup_sel2", bus.PSELECT2, !a[6]);
      chk("setup_penable", bus.PENABLE, 0);
      chk("setup_cmd", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {w, a, d});
      acc = 0;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK);
         if (rsp0_valid || rsp1_valid) begin
            got = 1'b1;
            break;
         end
         if (bus.PENABLE && (bus.PSELECT1 ^ bus.PSELECT2)) acc++;
      end
      chk("rsp_seen", got, 1);
      chk("access_cycles", acc, exp_acc);
      chk("rsp_owner", {rsp1_valid, rsp0_valid}, (r == 0) ? 2 'b01 : 2'b10);
      chk("rsp_rdata", (r == 0) ? rsp0_rdata : rsp1_rdata, exp_rd);
      chk("rsp_err", (r == 0) ? rsp0_err : rsp1_err, exp_err);
      chk("idle_bus", {bus.PSELECT1, bus.PSELECT2, bus.PENABLE}, 0);
      @(negedge PCLK);
      chk("rsp_pulse", {rsp1_valid, rsp0_valid}, 0);
   endtask

   initial begin
      int grants [$];
      int acc_at [$];
      logic [7:0] rdatas [$];
      int n0, n1, r0, r1, last, pend0, pend1, g;
      logic got;

      PRESET = 1'b1;
      req0_valid = 1'b1; req0_write = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 1'b1; req1_write = 0; req1_addr = 0; req1_wdata = 0;
      preload();
      @(negedge PCLK);
      #1;
      chk("reset_ready", {req1_ready, req0_ready}, 0);
      check_all_zero("reset");
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;

      add_vec(0, 1, 7'h41, 8'h05, 0,     0, 8'h00, 0);
      add_vec(1, 0, 7'h03, 8'h00, 3,     0, 8'h09, 0);
      add_vec(0, 1, 7'h45, 8'h77, 0,     1, 8'h00, 1);
      add_vec(0, 0, 7'h41, 8'h00, 1,     0, 8'h05, 0);
      add_vec(1, 1, 7'h10, 8'hAA, 2,     0, 8'h00, 0);
      add_vec(1, 0, 7'h10, 8'h00, 0,     0, 8'hAA, 0);
      add_vec(1, 0, 7'h22, 8'h00, 0,     1, 8'h22, 1);
      add_vec(0, 0, 7'h7F, 8'h00, STUCK, 0, 8'h00, 1);
      foreach (vecs[i])
         run_txn(vecs[i].req, vecs[i].cmd.write, vecs[i].cmd.addr, vecs[i].cmd.wdata,
                 vecs[i].waits, vecs[i].serr, vecs[i].exp_rdata, vecs[i].exp_err);

      // Contention from reset: both requesters hold four writes each.
      @(negedge PCLK);
      s_waits = 0; s_err = 0;
      PRESET = 1'b1;
      req0_valid = 1; req0_write = 1; req0_addr = 7'h50; req0_wdata = 8'h30;
      req1_valid = 1; req1_write = 1; req1_addr = 7'h20; req1_wdata = 8'h60;
      @(negedge PCLK);
      PRESET = 1'b0;
      n0 = 0; n1 = 0; r0 = 0; r1 = 0;
      for (int cyc = 0; cyc < 100 && (r0 < 4 || r1 < 4); cyc++) begin
         logic a0, a1;
         #1;
         a0 = req0_ready; a1 = req1_ready;
         if (a0) begin grants.push_back(0); acc_at.push_back(cyc); end
         if (a1) begin grants.push_back(1); acc_at.push_back(cyc); end
         if (rsp0_valid && !rsp0_err) r0++;
         if (rsp1_valid && !rsp1_err) r1++;
         @(posedge PCLK);
         #1;
         if (a0) begin
            n0++;
            if (n0 == 4) req0_valid = 0;
            else begin req0_addr = 7'h50 + 7'(n0); req0_wdata = 8'h30 + 8'(n0); end
         end
         if (a1) begin
            n1++;
            if (n1 == 4) req1_valid = 0;
            else begin req1_addr = 7'h20 + 7'(n1); req1_wdata = 8'h60 + 8'(n1); end
         end
         @(negedge PCLK);
      end
      chk("cont_grants", grants.size(), 8);
      chk("cont_rsp", {r0[7:0], r1[7:0]}, {8'd4, 8'd4});
      last = 1; pend0 = 4; pend1 = 4;
      foreach (grants[i]) begin
         g = (pend0 > 0 && pend1 > 0) ? 1 - last : ((pend0 > 0) ? 0 : 1);
         chk("cont_order", grants[i], g);
         if (g == 0) pend0--; else pend1--;
         last = g;
         if (i > 0) chk("cont_spacing", acc_at[i] - acc_at[i-1], 3);
      end

      // Back-to-back reads on requester 0.
      preload();
      @(negedge PCLK);
      grants.delete(); acc_at.delete();
      req0_valid = 1; req0_write = 0; req0_addr = 7'h40; n0 = 0;
      for (int cyc = 0; cyc < 60 && rdatas.size() < 6; cyc++) begin
         logic a0;
         #1;
         a0 = req0_ready;
         if (a0) acc_at.push_back(cyc);
         if (rsp0_valid) rdatas.push_back(rsp0_rdata);
         @(posedge PCLK);
         #1;
         if (a0) begin
            n0++;
            if (n0 == 6) req0_valid = 0;
            else req0_addr = 7'h40 + 7'(n0);
         end
         @(negedge PCLK);
      end
      chk("b2b_count", rdatas.size(), 6);
      foreach (rdatas[i]) chk("b2b_rdata", rdatas[i], ref_mem[7'h40 + i]);
      for (int i = 1; i < acc_at.size(); i++) chk("b2b_spacing", acc_at[i] - acc_at[i-1], 3);

      // Reset in the middle of a stalled ACCESS.
      @(negedge PCLK);
      s_waits = STUCK;
      req0_valid = 1; req0_write = 0; req0_addr = 7'h42; req0_wdata = 8'h11;
      @(posedge PCLK);
      #1 req0_valid = 0;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         if (bus.PENABLE) begin got = 1; break; end
      end
      chk("rst_reached_access", got, 1);
      @(negedge PCLK);
      PRESET = 1; req0_valid = 1;
      @(negedge PCLK);
      #1;
      chk("rst_ready_forced", req0_ready, 0);
      check_all_zero("midrst");
      req0_valid = 0; PRESET = 0; s_waits = 0;
      r0 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         if (rsp0_valid || rsp1_valid) r0++;
      end
      chk("rst_no_rsp", r0, 0);
      run_txn(0, 0, 7'h42, 8'h00, 0, 0, ref_mem[7'h42], 0);

      // Random isolated transfers against the memory model.
      for (int n = 0; n < 40; n++) begin
         int         r, waits;
         logic       w, serr;
         logic [6:0] a;
         logic [7:0] d, erd;
         r     = int'($urandom_range(0, 1));
         w     = 1'($urandom);
         a     = 7'($urandom);
         d     = 8'($urandom);
         waits = ($urandom_range(0, 9) == 0) ? STUCK : int'($urandom_range(0, 3));
         serr  = ($urandom_range(0, 7) == 0);
         if (waits >= STUCK) erd = 8'h00;
         else erd = w ? 8'h00 : ref_mem[a];
         run_txn(r, w, a, d, waits, serr, erd, (waits >= STUCK) ? 1'b1 : serr);
         if (w && !serr && waits < STUCK) ref_mem[a] = d;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
